// File: rtl/dma_pkg.sv
// dma_pkg: constants and types shared by the dma_copy engine and the data memory.
//   DMA_ADDR_W  default word-address width (memory depth 2**DMA_ADDR_W)
//   DMA_DATA_W  default word width
//   dma_state_e engine FSM state (IDLE, READ, WRITE, DONE)
package dma_pkg;

    localparam int unsigned DMA_ADDR_W = 10;
    localparam int unsigned DMA_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_e;

endpackage

// File: rtl/dma_copy.sv
// dma_copy: single-channel block-copy engine acting as initiator on the data
// memory load/store port. Copies len words from src_addr to dst_addr in strictly
// ascending order, one read then one write per word. With DMA_FILL_EN defined,
// fill=1 at start writes fill_data to dst..dst+len-1, one word per cycle.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   start               command strobe, sampled only in IDLE
//   src_addr, dst_addr  first source / destination word address
//   len                 word count 0..2**ADDR_W
//   busy, done          status: busy in READ/WRITE, one-cycle done pulse
//   Load, Store         memory read / write enables (never both high)
//   addr, write_data    memory word address and write data (0 when idle)
//   read_data           combinational memory read data
//   fill, fill_data     fill-mode select and constant (only with DMA_FILL_EN)
module dma_copy
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W = DMA_ADDR_W,
    parameter int unsigned DATA_W = DMA_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              Load,
    output logic              Store,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
`ifdef DMA_FILL_EN
    ,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data
`endif
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] data_buf_q, data_buf_d;
    logic              last_word;
    logic              fill_mode;
`ifdef DMA_FILL_EN
    logic              fill_q, fill_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;

    assign fill_mode = fill_q;
`else
    assign fill_mode = 1'b0;
`endif

    // len_q is never 0 outside IDLE, so len_q - 1 does not underflow when used.
    assign last_word = (cnt_q == (len_q - CNT_ONE));

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        data_buf_d = data_buf_q;
`ifdef DMA_FILL_EN
        fill_d      = fill_q;
        fill_data_d = fill_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        len_d   = len;
                        cnt_d   = '0;
                        state_d = READ;
`ifdef DMA_FILL_EN
                        fill_d      = fill;
                        fill_data_d = fill_data;
                        if (fill) begin
                            state_d = WRITE;
                        end
`endif
                    end
                end
            end
            READ: begin
                data_buf_d = read_data;
                state_d    = WRITE;
            end
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = fill_mode ? WRITE : READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are gated by rst_n so the strobes drop in the same cycle reset
    // is asserted, not one edge later.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        Load       = 1'b0;
        Store      = 1'b0;
        addr       = '0;
        write_data = '0;
        if (rst_n) begin
            case (state_q)
                READ: begin
                    busy = 1'b1;
                    Load = 1'b1;
                    addr = src_q + cnt_q[ADDR_W-1:0];
                end
                WRITE: begin
                    busy  = 1'b1;
                    Store = 1'b1;
                    addr  = dst_q + cnt_q[ADDR_W-1:0];
`ifdef DMA_FILL_EN
                    write_data = fill_q ? fill_data_q : data_buf_q;
`else
                    write_data = data_buf_q;
`endif
                end
                DONE: begin
                    done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            data_buf_q <= '0;
`ifdef DMA_FILL_EN
            fill_q      <= 1'b0;
            fill_data_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            data_buf_q <= data_buf_d;
`ifdef DMA_FILL_EN
            fill_q      <= fill_d;
            fill_data_q <= fill_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: directed bench for dma_copy with an attached 1024x16 memory.
// A word-level reference memory predicts every cycle's bus activity and the
// final memory image; literal checks pin the reference on the planned cases.
// Fill-mode cases are built only when DMA_FILL_EN is defined.
module tb_dma_copy;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, Load, Store;
    logic [AW-1:0] addr;
    logic [DW-1:0] write_data, read_data;
`ifdef DMA_FILL_EN
    logic          fill = 1'b0;
    logic [DW-1:0] fill_data = '0;
`endif

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] mm  [0:DEPTH-1];

    int errors = 0;
    int checks = 0;

    bit chk_en = 1'b1;
    bit exp_busy, exp_done, exp_load, exp_store;
    int exp_addr, exp_wd;

    dma_copy #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .Load       (Load),
        .Store      (Store),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data)
`ifdef DMA_FILL_EN
        ,
        .fill       (fill),
        .fill_data  (fill_data)
`endif
    );

    always #5 clk = ~clk;

    assign read_data = Load ? mem[addr] : '0;

    always @(posedge clk) begin
        if (Store) mem[addr] <= write_data;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of the bus against the expectation for this cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",       int'(busy),       int'(exp_busy));
            chk("done",       int'(done),       int'(exp_done));
            chk("Load",       int'(Load),       int'(exp_load));
            chk("Store",      int'(Store),      int'(exp_store));
            chk("addr",       int'(addr),       exp_addr);
            chk("write_data", int'(write_data), exp_wd);
        end
    end

    // Advance to just after the next rising edge and set what the cycle
    // starting there must show.
    task automatic step(input bit b, input bit d, input bit l, input bit s,
                        input int a, input int wd);
        @(posedge clk);
        #1;
        exp_busy  = b;
        exp_done  = d;
        exp_load  = l;
        exp_store = s;
        exp_addr  = a;
        exp_wd    = wd;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic poke(input int a, input int v);
        mem[a % DEPTH] = DW'(v);
        mm[a % DEPTH]  = DW'(v);
    endtask

    task automatic check_image(input string name);
        for (int a = 0; a < DEPTH; a++) begin
            if (mem[a] !== mm[a]) chk(name, int'(mem[a]), int'(mm[a]));
        end
        checks++;
    endtask

    // Copy: word k read in cycle 2k+1, written in 2k+2, done in 2n+1.
    task automatic run_copy(input int src, input int dst, input int n);
        logic [DW-1:0] v;
        src_addr = AW'(src);
        dst_addr = AW'(dst);
        len      = (AW+1)'(n);
        start    = 1'b1;
        for (int k = 0; k < n; k++) begin
            step(1, 0, 1, 0, (src + k) % DEPTH, 0);
            if (k == 0) begin
                start    = 1'b0;
                src_addr = ~src_addr;
                dst_addr = ~dst_addr;
                len      = '1;
            end
            v = mm[(src + k) % DEPTH];
            step(1, 0, 0, 1, (dst + k) % DEPTH, int'(v));
            // A start pulse while busy must be ignored.
            start = (k == 1);
            mm[(dst + k) % DEPTH] = v;
        end
        step(0, 1, 0, 0, 0, 0);
        start = 1'b1;          // sampled in DONE, must not be queued
        idle_step();
        start = 1'b0;
    endtask

`ifdef DMA_FILL_EN
    // Fill: word k written in cycle k+1, done in n+1.
    task automatic run_fill(input int dst, input int n, input int fd);
        dst_addr  = AW'(dst);
        src_addr  = 10'd0;
        len       = (AW+1)'(n);
        fill      = 1'b1;
        fill_data = DW'(fd);
        start     = 1'b1;
        for (int k = 0; k < n; k++) begin
            step(1, 0, 0, 1, (dst + k) % DEPTH, fd);
            if (k == 0) begin
                start     = 1'b0;
                fill      = 1'b0;
                fill_data = 16'h0;
            end
            mm[(dst + k) % DEPTH] = DW'(fd);
        end
        step(0, 1, 0, 0, 0, 0);
        idle_step();
    endtask
`endif

    initial begin
        for (int a = 0; a < DEPTH; a++) poke(a, 0);
        exp_busy = 0; exp_done = 0; exp_load = 0; exp_store = 0;
        exp_addr = 0; exp_wd = 0;

        // Reset state.
        idle_step();
        idle_step();
        rst_n = 1'b1;
        idle_step();

        // Basic copy.
        for (int k = 0; k < 4; k++) poke(k, k + 1);
        run_copy(0, 100, 4);
        for (int k = 0; k < 4; k++) chk("copy_lit", int'(mem[100 + k]), k + 1);
        check_image("copy_image");

        // Zero length, then back-to-back wrap copy.
        run_copy(5, 6, 0);
        poke(1022, 16'h1111);
        poke(1023, 16'h2222);
        run_copy(1022, 10, 4);
        chk("wrap_lit0", int'(mem[10]), 16'h1111);
        chk("wrap_lit1", int'(mem[11]), 16'h2222);
        chk("wrap_lit2", int'(mem[12]), 1);
        chk("wrap_lit3", int'(mem[13]), 2);
        check_image("wrap_image");

        // Destination wrap.
        poke(50, 16'h5A5A);
        poke(51, 16'hA5A5);
        run_copy(50, 1023, 2);
        chk("dwrap_lit0", int'(mem[1023]), 16'h5A5A);
        chk("dwrap_lit1", int'(mem[0]), 16'hA5A5);

        // Overlap, dst > src.
        poke(0, 16'hA);
        poke(1, 16'hB);
        poke(2, 16'hC);
        poke(3, 16'hD);
        run_copy(0, 1, 3);
        for (int k = 1; k < 4; k++) chk("overlap_lit", int'(mem[k]), 16'hA);
        check_image("overlap_image");

        // Reset during cycle 3 of an 8-word copy.
        for (int k = 0; k < 8; k++) begin
            poke(200 + k, 16'h700 + k);
            poke(300 + k, 0);
        end
        src_addr = 10'd200;
        dst_addr = 10'd300;
        len      = 11'd8;
        start    = 1'b1;
        step(1, 0, 1, 0, 200, 0);
        start = 1'b0;
        step(1, 0, 0, 1, 300, 16'h700);
        mm[300] = 16'h700;
        idle_step();
        rst_n = 1'b0;
        idle_step();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) idle_step();
        chk("rst_written", int'(mem[300]), 16'h700);
        chk("rst_untouched", int'(mem[301]), 0);
        check_image("rst_image");

`ifdef DMA_FILL_EN
        run_fill(500, 3, 16'hBEEF);
        for (int k = 0; k < 3; k++) chk("fill_lit", int'(mem[500 + k]), 16'hBEEF);
        check_image("fill_image");
        run_copy(500, 600, 2);
        chk("after_fill_copy", int'(mem[601]), 16'hBEEF);
`endif

        idle_step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
